// File: rtl/gprs_pkg.sv
// gprs_pkg: definitions shared by the register file, the pipeline and the
// write-back queue.
//   REG_AW    register address width (32 architectural registers)
//   DATA_W    register data width
//   wr_req_t  one register-write request {addr, data}
//   WR_REQ_W  packed width of wr_req_t
package gprs_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  localparam int WR_REQ_W = $bits(wr_req_t);

endpackage

// File: rtl/gprs_wb_match.sv
// gprs_wb_match: combinational newest-match search over the write-back queue.
//   entry_addr/entry_data  raw storage of the circular buffer
//   rd_ptr                 index of the oldest (head) entry
//   count                  number of occupied entries
//   addr                   lookup address
//   hit                    some occupied entry targets addr
//   data                   data of the most recently pushed match, 0 if no hit
module gprs_wb_match
  import gprs_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = DATA_W
) (
  input  logic [DEPTH-1:0][REG_AW-1:0]     entry_addr,
  input  logic [DEPTH-1:0][DW-1:0]         entry_data,
  input  logic [$clog2(DEPTH)-1:0]         rd_ptr,
  input  logic [$clog2(DEPTH+1)-1:0]       count,
  input  logic [REG_AW-1:0]                addr,
  output logic                             hit,
  output logic [DW-1:0]                    data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Walk from oldest to newest so a later (younger) match overrides an
  // earlier one; only the first 'count' slots from the head are live.
  always_comb begin
    // NOTE: defaults first so every path assigns hit/data and no latch forms.
    hit  = 1'b0;
    data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count && entry_addr[rd_ptr + PW'(k)] == addr) begin
        hit  = 1'b1;
        data = entry_data[rd_ptr + PW'(k)];
      end
    end
  end

endmodule

// File: rtl/gprs_wb.sv
// gprs_wb: in-order write-back queue feeding the register file write port.
//   Clk, Reset              clock, synchronous active-high reset
//   In_valid/In_ready       request handshake; In_addr/In_data the request
//   Drain_en                write port free this cycle
//   Regwrite/A3/Wd          register file write port (head of the queue)
//   A1/A2 -> Hit1/Fwd1, Hit2/Fwd2   newest pending value for each read address
//   Count                   occupied entries
module gprs_wb
  import gprs_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = DATA_W
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        In_valid,
  output logic                        In_ready,
  input  logic [REG_AW-1:0]           In_addr,
  input  logic [DW-1:0]               In_data,
  input  logic                        Drain_en,
  output logic                        Regwrite,
  output logic [REG_AW-1:0]           A3,
  output logic [DW-1:0]               Wd,
  input  logic [REG_AW-1:0]           A1,
  input  logic [REG_AW-1:0]           A2,
  output logic                        Hit1,
  output logic                        Hit2,
  output logic [DW-1:0]               Fwd1,
  output logic [DW-1:0]               Fwd2,
  output logic [$clog2(DEPTH+1)-1:0]  Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][REG_AW-1:0] addr_q;
  logic [DEPTH-1:0][DW-1:0]     data_q;
  logic [PW-1:0]                wr_ptr;
  logic [PW-1:0]                rd_ptr;
  logic [CW-1:0]                count_q;
  logic                         push;
  logic                         pop;
  logic                         not_empty;

  // Ready looks only at the registered count: a same-cycle pop never frees
  // a slot for a push, which keeps In_ready off the Drain_en path.
  assign In_ready  = (count_q != CW'(DEPTH));
  assign not_empty = (count_q != '0);
  assign push      = In_valid && In_ready;
  assign pop       = Regwrite;

  assign Regwrite = not_empty && Drain_en;
  assign A3       = not_empty ? addr_q[rd_ptr] : '0;
  assign Wd       = not_empty ? data_q[rd_ptr] : '0;
  assign Count    = count_q;

  // NOTE: the entry storage has no reset; stale slots are never observed
  // because every reader qualifies them with count_q.
  always_ff @(posedge Clk) begin
    if (push) begin
      addr_q[wr_ptr] <= In_addr;
      data_q[wr_ptr] <= In_data;
    end
  end

  // Reset takes priority, so a push in the reset cycle is dropped.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      // NOTE: sequential state uses non-blocking assignments throughout.
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  gprs_wb_match #(.DEPTH(DEPTH), .DW(DW)) u_match1 (
    .entry_addr (addr_q),
    .entry_data (data_q),
    .rd_ptr     (rd_ptr),
    .count      (count_q),
    .addr       (A1),
    .hit        (Hit1),
    .data       (Fwd1)
  );

  gprs_wb_match #(.DEPTH(DEPTH), .DW(DW)) u_match2 (
    .entry_addr (addr_q),
    .entry_data (data_q),
    .rd_ptr     (rd_ptr),
    .count      (count_q),
    .addr       (A2),
    .hit        (Hit2),
    .data       (Fwd2)
  );

endmodule

// File: tb/tb_gprs_wb.sv
// tb_gprs_wb: self-checking bench for gprs_wb. A queue of pending requests
// models the design; every cycle all outputs are compared against it, and
// directed scenarios add fixed expectations on top.
module tb_gprs_wb;
  import gprs_pkg::*;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH+1);

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_addr;
  logic [DW-1:0]     in_data;
  logic              drain_en;
  logic              regwrite;
  logic [4:0]        a3;
  logic [DW-1:0]     wd;
  logic [4:0]        a1;
  logic [4:0]        a2;
  logic              hit1;
  logic              hit2;
  logic [DW-1:0]     fwd1;
  logic [DW-1:0]     fwd2;
  logic [CW-1:0]     count;

  gprs_wb #(.DEPTH(DEPTH), .DW(DW)) dut (
    .Clk      (clk),
    .Reset    (rst),
    .In_valid (in_valid),
    .In_ready (in_ready),
    .In_addr  (in_addr),
    .In_data  (in_data),
    .Drain_en (drain_en),
    .Regwrite (regwrite),
    .A3       (a3),
    .Wd       (wd),
    .A1       (a1),
    .A2       (a2),
    .Hit1     (hit1),
    .Hit2     (hit2),
    .Fwd1     (fwd1),
    .Fwd2     (fwd2),
    .Count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Pending requests, oldest at index 0.
  wr_req_t model_q[$];

  // Outputs seen in the most recent step, for directed expectations.
  logic          obs_ready, obs_rw, obs_hit1;
  logic [4:0]    obs_a3;
  logic [DW-1:0] obs_wd, obs_fwd1;
  logic [CW-1:0] obs_count;

  // Returns {hit, data} for the newest pending request to addr.
  function automatic logic [DW:0] lookup(input logic [4:0] addr);
    for (int i = model_q.size() - 1; i >= 0; i--)
      if (model_q[i].addr == addr) return {1'b1, model_q[i].data};
    return '0;
  endfunction

  // One clock cycle: drive inputs, compare at the falling edge, then advance
  // the model across the rising edge. Entered and left at posedge + 1.
  task automatic step(input logic v, input logic [4:0] ad, input logic [DW-1:0] d,
                      input logic dr, input logic [4:0] r1, input logic [4:0] r2,
                      input logic rs);
    logic          exp_ready, exp_rw;
    logic [4:0]    exp_a3;
    logic [DW-1:0] exp_wd;
    logic [DW:0]   l1, l2;
    in_valid = v; in_addr = ad; in_data = d; drain_en = dr;
    a1 = r1; a2 = r2; rst = rs;
    #4;
    exp_ready = (model_q.size() != DEPTH);
    exp_rw    = (model_q.size() != 0) && dr;
    exp_a3    = (model_q.size() != 0) ? model_q[0].addr : 5'd0;
    exp_wd    = (model_q.size() != 0) ? model_q[0].data : '0;
    l1 = lookup(r1);
    l2 = lookup(r2);
    check("count",    64'(count),    64'(model_q.size()));
    check("in_ready", 64'(in_ready), 64'(exp_ready));
    check("regwrite", 64'(regwrite), 64'(exp_rw));
    check("a3",       64'(a3),       64'(exp_a3));
    check("wd",       64'(wd),       64'(exp_wd));
    check("hit1",     64'(hit1),     64'(l1[DW]));
    check("fwd1",     64'(fwd1),     64'(l1[DW-1:0]));
    check("hit2",     64'(hit2),     64'(l2[DW]));
    check("fwd2",     64'(fwd2),     64'(l2[DW-1:0]));
    obs_ready = in_ready; obs_rw = regwrite; obs_hit1 = hit1;
    obs_a3 = a3; obs_wd = wd; obs_fwd1 = fwd1; obs_count = count;
    @(posedge clk);
    if (rs) begin
      model_q.delete();
    end else begin
      if (exp_rw) void'(model_q.pop_front());
      if (v && exp_ready) model_q.push_back('{addr: ad, data: d});
    end
    #1;
  endtask

  task automatic idle(input logic dr, input logic [4:0] r1);
    step(1'b0, 5'd0, '0, dr, r1, 5'd0, 1'b0);
  endtask

  task automatic push(input logic [4:0] ad, input logic [DW-1:0] d, input logic dr);
    step(1'b1, ad, d, dr, 5'd0, 5'd0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
    drain_en = 1'b0; a1 = '0; a2 = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset values.
    idle(1'b1, 5'd0);
    check("rst_count", 64'(obs_count), 64'd0);
    check("rst_ready", 64'(obs_ready), 64'd1);

    // Single push, written in the next cycle.
    push(5'd5, 32'h1234, 1'b1);
    idle(1'b1, 5'd0);
    check("single_rw", 64'(obs_rw), 64'd1);
    check("single_a3", 64'(obs_a3), 64'd5);
    check("single_wd", 64'(obs_wd), 64'h1234);
    idle(1'b1, 5'd0);
    check("single_cnt", 64'(obs_count), 64'd0);
    check("single_rw0", 64'(obs_rw), 64'd0);

    // Fill while stalled, 5th push ignored, then drain in order.
    for (int i = 1; i <= 4; i++) push(5'(i), 32'hA0 + 32'(i), 1'b0);
    push(5'd9, 32'hFF, 1'b0);
    check("full_cnt", 64'(obs_count), 64'd4);
    check("full_rdy", 64'(obs_ready), 64'd0);
    for (int i = 1; i <= 4; i++) begin
      idle(1'b1, 5'd0);
      check("order_rw", 64'(obs_rw), 64'd1);
      check("order_a3", 64'(obs_a3), 64'(i));
    end
    idle(1'b1, 5'd0);
    check("dropped_5th", 64'(obs_count), 64'd0);

    // Newest-match forwarding with duplicate addresses.
    push(5'd7, 32'hA, 1'b0);
    push(5'd7, 32'hB, 1'b0);
    idle(1'b0, 5'd7);
    check("fwd_hit", 64'(obs_hit1), 64'd1);
    check("fwd_new", 64'(obs_fwd1), 64'hB);
    idle(1'b1, 5'd7);
    idle(1'b0, 5'd7);
    check("fwd_after1", 64'(obs_fwd1), 64'hB);
    idle(1'b1, 5'd7);
    check("fwd_head", 64'(obs_fwd1), 64'hB);
    idle(1'b0, 5'd7);
    check("fwd_gone", 64'(obs_hit1), 64'd0);

    // Sustained push + drain across pointer wrap.
    for (int i = 0; i < 20; i++) begin
      push(5'(i), 32'h100 + 32'(i), 1'b1);
      if (i > 0) begin
        check("stream_wd",  64'(obs_wd),    64'(32'h100 + 32'(i - 1)));
        check("stream_cnt", 64'(obs_count), 64'd1);
      end
    end
    idle(1'b1, 5'd0);
    check("stream_last", 64'(obs_wd), 64'h113);
    idle(1'b1, 5'd0);

    // Reset with pending entries and a concurrent push.
    for (int i = 0; i < 3; i++) push(5'(20 + i), 32'hC0 + 32'(i), 1'b0);
    step(1'b1, 5'd3, 32'hDEAD, 1'b0, 5'd3, 5'd20, 1'b1);
    idle(1'b1, 5'd3);
    check("mrst_cnt", 64'(obs_count), 64'd0);
    check("mrst_rw",  64'(obs_rw),    64'd0);
    check("mrst_hit", 64'(obs_hit1),  64'd0);

    // Full queue: pop happens, simultaneous push rejected, accepted next.
    for (int i = 0; i < 4; i++) push(5'(10 + i), 32'hD0 + 32'(i), 1'b0);
    push(5'd15, 32'hEE, 1'b1);
    check("fullpop_rdy", 64'(obs_ready), 64'd0);
    check("fullpop_rw",  64'(obs_rw),    64'd1);
    push(5'd15, 32'hEE, 1'b1);
    check("fullpop_cnt", 64'(obs_count), 64'd3);
    check("fullpop_rdy1", 64'(obs_ready), 64'd1);
    idle(1'b0, 5'd15);
    check("fullpop_cnt2", 64'(obs_count), 64'd3);
    check("fullpop_fwd", 64'(obs_fwd1), 64'hEE);
    repeat (3) idle(1'b1, 5'd0);

    // Randomized traffic with varying push/drain pressure.
    for (int i = 0; i < 600; i++) begin
      int          bias;
      logic        v, dr, rs;
      bias = (i / 100) % 3;
      v  = ($urandom_range(0, 3) < (bias == 0 ? 3 : 2));
      dr = ($urandom_range(0, 3) < (bias == 1 ? 3 : (bias == 2 ? 1 : 2)));
      rs = ($urandom_range(0, 63) == 0);
      step(v, 5'($urandom_range(0, 7)), DW'($urandom), dr,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), rs);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gprs_wb.md
# gprs_wb

Write-back queue that acts as the writer for the general-purpose register file. It accepts register-write requests from the execute/memory stages over a valid/ready handshake and buffers them in a small in-order FIFO. It drains the FIFO into the register file's single write port (Regwrite/A3/Wd), at most one entry per cycle. It also provides newest-match forwarding of pending writes for the two read addresses, so the pipeline never reads stale register contents.

## Interface
Parameters:
- DEPTH, 4: queue entries; must be a power of two, ≥ 2.
- DW, 32: data width.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high; sampled on the rising edge of Clk.
- In_valid  in  1  a write request is present.
- In_ready  out  1  queue can accept a request.
- In_addr  in  5  destination register.
- In_data  in  DW  value to write.
- Drain_en  in  1  write port is available this cycle.
- Regwrite  out  1  write strobe to the register file.
- A3  out  5  write address to the register file.
- Wd  out  DW  write data to the register file.
- A1, A2  in  5  read addresses presented to the register file.
- Hit1, Hit2  out  1  the read address matches a pending entry.
- Fwd1, Fwd2  out  DW  newest pending value for A1/A2; 0 when there is no hit.
- Count  out  $clog2(DEPTH+1)  number of occupied entries.

## Operation
- Storage: circular buffer of {addr[4:0], data[DW-1:0]} with a write pointer, a read pointer and an occupancy count.
- Push: occurs when In_valid && In_ready.
  - The entry is stored at the write pointer.
  - The write pointer increments, wrapping modulo DEPTH.
- In_ready = (Count != DEPTH). It depends only on the registered count. A pop in the same cycle does not make room for a push when the queue is full.
- Head drive (combinational from the head entry):
  - Regwrite = (Count != 0) && Drain_en.
  - A3 = head address; Wd = head data.
  - A3/Wd are undefined-but-stable when the queue is empty; drive 0.
- Pop: occurs when Regwrite is high. The read pointer increments with wrap.
- Simultaneous push and pop: Count is unchanged and both pointers advance.
- Entries are written strictly in arrival order. Duplicate addresses are kept as separate entries; the last one written wins in the register file.
- Register 0 gets no special handling; writes to it pass through like any other address.
- Forwarding (combinational):
  - For each of A1/A2, search all occupied entries, including the head being written this cycle.
  - The most recently pushed match wins.
  - A request being pushed in the same cycle is not visible to the search.
- Reset:
  - Clears both pointers and Count. Pending entries are discarded, including when reset occurs mid-drain.
  - Entry contents need not be cleared.

## Timing
- Values after a Reset edge: Count=0, In_ready=1, Regwrite=0, A3=0, Wd=0, Hit1=Hit2=0, Fwd1=Fwd2=0.
- Latency:
  - A request pushed at edge N is presented on Regwrite/A3/Wd in cycle N+1, provided the queue was empty and Drain_en=1.
  - The register file captures it at edge N+1.
- Forwarding hits appear in the cycle after the push edge and remain until the pop edge of that entry. The register file holds the value from then on.
- Throughput: one push and one pop per cycle sustained.
- Drain_en low stalls the drain; entries and Count hold.
- Full: In_ready drops in the cycle after the DEPTH-th push. A push attempt while In_ready=0 is ignored and does not change state.
- Reset and push in the same cycle: reset wins and the push is dropped.

## Structure
- Shared header/package gprs_pkg:
  - REG_AW=5, DATA_W=32.
  - Write-request entry record {addr, data} and its packed width.
  - Shared with the register file and the pipeline.
- One sub-module: gprs_wb_match. Combinational priority search over DEPTH entries, given the read pointer, Count and a lookup address; returns hit and data. It is instantiated twice, for A1 and A2.
- The remaining logic (pointers, count, handshake, head drive) lives in gprs_wb.

## Test plan
- Reset, then a single push {addr 5, data 0x1234} with Drain_en=1 → next cycle Regwrite=1, A3=5, Wd=0x1234; one cycle later Count=0 and Regwrite=0.
- Drain_en=0, push 4 entries to registers 1..4 → Count=4, In_ready=0. A 5th push is ignored. Raise Drain_en → writes to 1,2,3,4 on consecutive cycles, in order.
- Drain_en=0, push {7,0xA} then {7,0xB}, A1=7 → Hit1=1, Fwd1=0xB. Drain one entry → still Fwd1=0xB. Drain the second → Hit1=0.
- Continuous push and drain for 20 cycles with distinct data → every value appears exactly once on Wd, in order, across pointer wrap; Count stays 1.
- Fill with 3 entries, assert Reset for one cycle together with In_valid → Count=0, Regwrite=0, no write from either the discarded entries or the dropped push.
- Full queue with Drain_en=1 and In_valid=1 → pop occurs and the push is rejected. Count goes from 4 to 3, then the push is accepted on the next cycle.
